// File: rtl/mem_slave_if.sv
// Request/response bus between the master driver and the memory slave.
interface mem_slave_if #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 4
);
    logic                  wr_rd;
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      wdata;
    logic                  ready;
    logic [WIDTH-1:0]      rdata;

    modport master (
        output wr_rd, valid, addr, wdata,
        input  ready, rdata
    );

    modport slave (
        input  wr_rd, valid, addr, wdata,
        output ready, rdata
    );
endinterface

// File: rtl/mem_slave.sv
// Single-port memory slave: zero-wait-state writes, reads stalled via ready
// for RD_LATENCY cycles to model array access time.
module mem_slave #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int RD_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    mem_slave_if.slave  bus
);
    localparam int         DEPTH  = 2 ** ADDR_WIDTH;
    localparam logic [3:0] CNT_LD = 4'(RD_LATENCY - 1);

    if (RD_LATENCY < 1 || RD_LATENCY > 15) begin : g_bad_latency
        $fatal(1, "mem_slave: RD_LATENCY must be in 1..15");
    end

    typedef enum logic [1:0] {
        RESET_WAIT,
        IDLE,
        RD_WAIT
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_ready;
    logic                  w_ready_nxt;
    logic                  w_rd_done;
    logic [WIDTH-1:0]      r_rdata;
    logic [3:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [WIDTH-1:0]      r_mem [DEPTH];

    logic w_accept;
    logic w_wr_acc;
    logic w_rd_acc;

    assign w_accept = bus.valid && r_ready && (r_state == IDLE);
    assign w_wr_acc = w_accept && bus.wr_rd;
    assign w_rd_acc = w_accept && !bus.wr_rd;

    assign bus.ready = r_ready;
    assign bus.rdata = r_rdata;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RESET_WAIT;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode, registered-ready next value, read completion strobe
    always_comb begin
        w_next      = r_state;
        w_ready_nxt = r_ready;
        w_rd_done   = 1'b0;
        case (r_state)
            RESET_WAIT: begin
                w_next      = IDLE;
                w_ready_nxt = 1'b1;
            end
            IDLE: begin
                w_ready_nxt = 1'b1;
                if (w_rd_acc) begin
                    w_next      = RD_WAIT;
                    w_ready_nxt = 1'b0;
                end
            end
            RD_WAIT: begin
                w_ready_nxt = 1'b0;
                if (r_cnt == 4'd0) begin
                    w_next      = IDLE;
                    w_ready_nxt = 1'b1;
                    w_rd_done   = 1'b1;
                end
            end
            default: begin
                w_next      = RESET_WAIT;
                w_ready_nxt = 1'b0;
            end
        endcase
    end

    // Registered ready output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= w_ready_nxt;
        end
    end

    // Latency counter and latched read address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_addr <= '0;
        end else if (w_rd_acc) begin
            r_cnt  <= CNT_LD;
            r_addr <= bus.addr;
        end else if (r_state == RD_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Storage array: cleared on reset, written on accepted writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_acc) begin
            r_mem[bus.addr] <= bus.wdata;
        end
    end

    // Read data register: only updated at read completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (w_rd_done) begin
            r_rdata <= r_mem[r_addr];
        end
    end
endmodule

// File: tb/tb_mem_slave.sv
// Self-checking bench for mem_slave: three instances (RD_LATENCY 2, 1, 15)
// checked against a behavioural array model with directed and random traffic.
module tb_mem_slave;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mem_slave_if #(.WIDTH(16), .ADDR_WIDTH(4)) b0 ();
    mem_slave_if #(.WIDTH(16), .ADDR_WIDTH(4)) b1 ();
    mem_slave_if #(.WIDTH(16), .ADDR_WIDTH(4)) b2 ();

    mem_slave #(.WIDTH(16), .ADDR_WIDTH(4), .RD_LATENCY(2))  u_dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
    mem_slave #(.WIDTH(16), .ADDR_WIDTH(4), .RD_LATENCY(1))  u_dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
    mem_slave #(.WIDTH(16), .ADDR_WIDTH(4), .RD_LATENCY(15)) u_dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

    logic        t_valid [3];
    logic        t_wr_rd [3];
    logic [3:0]  t_addr  [3];
    logic [15:0] t_wdata [3];
    logic        w_ready [3];
    logic [15:0] w_rdata [3];

    assign b0.valid = t_valid[0]; assign b0.wr_rd = t_wr_rd[0];
    assign b0.addr  = t_addr[0];  assign b0.wdata = t_wdata[0];
    assign b1.valid = t_valid[1]; assign b1.wr_rd = t_wr_rd[1];
    assign b1.addr  = t_addr[1];  assign b1.wdata = t_wdata[1];
    assign b2.valid = t_valid[2]; assign b2.wr_rd = t_wr_rd[2];
    assign b2.addr  = t_addr[2];  assign b2.wdata = t_wdata[2];
    assign w_ready[0] = b0.ready; assign w_rdata[0] = b0.rdata;
    assign w_ready[1] = b1.ready; assign w_rdata[1] = b1.rdata;
    assign w_ready[2] = b2.ready; assign w_rdata[2] = b2.rdata;

    int lat [3] = '{2, 1, 15};

    // Reference model: plain word array per instance plus last read value
    logic [15:0] m_mem   [3][16];
    logic [15:0] m_rdata [3];

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_rdata[k] = '0;
            for (int a = 0; a < 16; a++) m_mem[k][a] = '0;
        end
    endtask

    // Drive a request and wait (bounded) until it is accepted; returns with valid still high
    task automatic wait_accept(input int k, output int waits);
        waits = 0;
        while (w_ready[k] !== 1'b1 && waits < 50) begin
            @(posedge clk); #1;
            waits++;
        end
        chk("accept_bound", 32'(waits < 50), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic do_write(input int k, input logic [3:0] a, input logic [15:0] d, output int waits);
        t_valid[k] = 1'b1; t_wr_rd[k] = 1'b1; t_addr[k] = a; t_wdata[k] = d;
        wait_accept(k, waits);
        t_valid[k] = 1'b0;
        m_mem[k][a] = d;
        chk("wr_rdata_hold", w_rdata[k], m_rdata[k]);
    endtask

    // Read; optionally hold a write valid on the bus while the read is stalled
    task automatic do_read(input int k, input logic [3:0] a, input bit hold_wr,
                           input logic [3:0] wa, input logic [15:0] wd);
        int waits;
        int n;
        t_valid[k] = 1'b1; t_wr_rd[k] = 1'b0; t_addr[k] = a;
        wait_accept(k, waits);
        if (hold_wr) begin
            t_wr_rd[k] = 1'b1; t_addr[k] = wa; t_wdata[k] = wd;
        end else begin
            t_valid[k] = 1'b0;
        end
        n = 0;
        while (w_ready[k] !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rd_latency", n, lat[k]);
        m_rdata[k] = m_mem[k][a];
        chk("rd_data", w_rdata[k], m_rdata[k]);
        if (hold_wr) begin
            @(posedge clk); #1;
            t_valid[k] = 1'b0;
            m_mem[k][wa] = wd;
            chk("stall_wr_rdata_hold", w_rdata[k], m_rdata[k]);
        end
    endtask

    initial begin
        int waits;
        logic [3:0]  ra;
        logic [15:0] rd;
        for (int k = 0; k < 3; k++) begin
            t_valid[k] = 1'b0; t_wr_rd[k] = 1'b0; t_addr[k] = '0; t_wdata[k] = '0;
        end
        model_reset();

        // Reset held for three edges
        #1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) begin
                chk("rst_ready", w_ready[k], 32'd0);
                chk("rst_rdata", w_rdata[k], 32'd0);
            end
        end
        rst = 1'b0;
        chk("post_rst_ready_pre_edge", w_ready[0], 32'd0);
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) chk("post_rst_ready", w_ready[k], 32'd1);
        do_read(0, 4'd5, 1'b0, '0, '0);
        chk("rd_reset_mem", w_rdata[0], 32'h0000);

        // Write then read
        do_write(0, 4'd3, 16'hA5A5, waits);
        chk("wr_no_wait", waits, 32'd0);
        do_read(0, 4'd3, 1'b0, '0, '0);
        chk("rd_a5a5", w_rdata[0], 32'hA5A5);

        // Back-to-back writes, one per cycle
        for (int a = 0; a < 16; a++) begin
            do_write(0, 4'(a), 16'(a * 16'h1111), waits);
            chk("b2b_no_wait", waits, 32'd0);
            chk("b2b_ready", w_ready[0], 32'd1);
        end
        do_read(0, 4'd15, 1'b0, '0, '0);
        chk("rd_ffff", w_rdata[0], 32'hFFFF);
        do_read(0, 4'd7, 1'b0, '0, '0);
        chk("rd_7777", w_rdata[0], 32'h7777);

        // Stall rule: write held during RD_WAIT is not taken early
        do_read(0, 4'd1, 1'b1, 4'd1, 16'hDEAD);
        chk("stall_old_value", w_rdata[0], 32'h1111);
        do_read(0, 4'd1, 1'b0, '0, '0);
        chk("stall_new_value", w_rdata[0], 32'hDEAD);

        // Latency sweep on the 1- and 15-cycle instances
        for (int k = 1; k < 3; k++) begin
            do_write(k, 4'd9, 16'hBEEF, waits);
            do_read(k, 4'd9, 1'b0, '0, '0);
            chk("sweep_data", w_rdata[k], 32'hBEEF);
        end

        // Random traffic against the model
        for (int i = 0; i < 90; i++) begin
            int k;
            k  = int'($urandom_range(0, 2));
            ra = 4'($urandom_range(0, 15));
            rd = 16'($urandom);
            if ($urandom_range(0, 1) == 1) do_write(k, ra, rd, waits);
            else                           do_read(k, ra, 1'b0, '0, '0);
        end

        // Reset mid-read: aborted read never lands
        do_write(0, 4'd2, 16'h1234, waits);
        t_valid[0] = 1'b1; t_wr_rd[0] = 1'b0; t_addr[0] = 4'd2;
        wait_accept(0, waits);
        t_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrd_rst_ready", w_ready[0], 32'd0);
        chk("midrd_rst_rdata", w_rdata[0], 32'd0);
        model_reset();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("midrd_rdata_stays0", w_rdata[0], 32'd0);
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("midrd_no_late_update", w_rdata[0], 32'd0);
        end
        chk("midrd_ready_back", w_ready[0], 32'd1);
        do_read(0, 4'd2, 1'b0, '0, '0);
        chk("midrd_mem_cleared", w_rdata[0], 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    // Global time limit so the bench always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
